// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: streaming multiply-accumulate over valid/ready, one term per cycle.
// Optional build macro DOTACC_SATURATE_EN clamps the accumulator instead of wrapping on overflow.
`default_nettype none

module unsigned_parallel_multiplier #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           carry_out
);
  logic [2*W:0] partial_sum [0:W];

  assign partial_sum[0] = '0;

  for (genvar i = 0; i < W; i++) begin : g_row
    assign partial_sum[i+1] = partial_sum[i] + ({{(W+1){1'b0}}, a & {W{b[i]}}} << i);
  end

  assign product   = partial_sum[W][2*W-1:0];
  assign carry_out = partial_sum[W][2*W];
endmodule

module dot_product_accumulator #(
  parameter int W     = 4,
  parameter int N     = 8,
  parameter int ACC_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_x,
  input  logic [W-1:0]             in_y,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_acc,
  output logic [$clog2(N+1)-1:0]   out_count,
  output logic                     out_ovf
);
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [W-1:0]     x_r, y_r;
  logic             last_r, s1_valid;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    count;
  logic             ovf;

  logic             accept, beat_last, handshake;
  logic [CW-1:0]    seen;
  logic [2*W-1:0]   product;
  logic             mult_unused_carry;
  logic [ACC_W:0]   sum;

  assign in_ready  = (state == ACC) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Terms accepted so far: those already accumulated plus the one sitting in stage 1.
  assign seen      = count + CW'(s1_valid);
  assign beat_last = in_last || (seen == CW'(N-1));

  unsigned_parallel_multiplier #(.W(W)) u_mult (
    .a         (x_r),
    .b         (y_r),
    .product   (product),
    .carry_out (mult_unused_carry)
  );

  assign sum = {1'b0, acc} + {{(ACC_W+1-2*W){1'b0}}, product};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      x_r      <= '0;
      y_r      <= '0;
      last_r   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        x_r    <= in_x;
        y_r    <= in_y;
        last_r <= beat_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (handshake) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (s1_valid) begin
      count <= count + CW'(1);
      if (sum[ACC_W]) ovf <= 1'b1;
`ifdef DOTACC_SATURATE_EN
      acc <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc <= sum[ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (accept && beat_last) state_next = DRAIN;
      // Leave once the final term has left stage 1 and been summed.
      DRAIN:   if (!(s1_valid && last_r)) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;
endmodule

`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: directed test-plan vectors plus randomized vectors.
`default_nettype none

module tb_dot_product_accumulator;
  localparam int W     = 4;
  localparam int N     = 8;
  localparam int ACC_W = 10;
  localparam int CW    = $clog2(N+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [W-1:0]     in_x, in_y;
  logic             out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0] out_acc;
  logic [CW-1:0]    out_count;

  int checks = 0;
  int errors = 0;

  int unsigned xs [N];
  int unsigned ys [N];
  bit          lasts [N];

  dot_product_accumulator #(.W(W), .N(N), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer dot product, then wrap or clamp to the accumulator range.
  function automatic int unsigned model_acc(input int unsigned total);
    int unsigned max_val;
    max_val = (1 << ACC_W) - 1;
`ifdef DOTACC_SATURATE_EN
    return (total > max_val) ? max_val : total;
`else
    return total % (1 << ACC_W);
`endif
  endfunction

  function automatic int vector_terms();
    for (int k = 0; k < N; k++)
      if (lasts[k]) return k + 1;
    return N;
  endfunction

  task automatic clear_beats();
    for (int k = 0; k < N; k++) begin
      xs[k] = 0; ys[k] = 0; lasts[k] = 1'b0;
    end
  endtask

  // Drives beats 0..terms-1; returns 1 ns after the edge accepting the last one.
  task automatic send_beats(input int terms, input bit gaps);
    for (int k = 0; k < terms; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_value("gap_ready", in_ready, 1);
      end
      in_valid = 1'b1;
      in_x     = xs[k][W-1:0];
      in_y     = ys[k][W-1:0];
      in_last  = lasts[k];
      check_value("beat_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_x     = W'($urandom);
    in_y     = W'($urandom);
  endtask

  task automatic run_vector(input int hold, input bit gaps);
    int          terms;
    int unsigned total, exp_acc;
    bit          exp_ovf;
    terms = vector_terms();
    total = 0;
    for (int k = 0; k < terms; k++) total += xs[k] * ys[k];
    exp_acc = model_acc(total);
    exp_ovf = (total > (1 << ACC_W) - 1);

    out_ready = (hold == 0);
    send_beats(terms, gaps);
    check_value("drain_ready", in_ready, 0);
    check_value("drain_valid", out_valid, 0);
    @(posedge clk); #1;
    check_value("pipe_valid", out_valid, 0);
    check_value("pipe_ready", in_ready, 0);
    @(posedge clk); #1;
    check_value("out_valid", out_valid, 1);
    check_value("out_acc", out_acc, exp_acc);
    check_value("out_count", out_count, terms);
    check_value("out_ovf", out_ovf, exp_ovf);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_value("hold_valid", out_valid, 1);
      check_value("hold_acc", out_acc, exp_acc);
      check_value("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_value("post_valid", out_valid, 0);
    check_value("post_ready", in_ready, 1);
    check_value("post_acc", out_acc, 0);
    check_value("post_count", out_count, 0);
    check_value("post_ovf", out_ovf, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    check_value("rst_ready", in_ready, 0);
    check_value("rst_valid", out_valid, 0);
    check_value("rst_acc", out_acc, 0);
    check_value("rst_count", out_count, 0);
    check_value("rst_ovf", out_ovf, 0);
    rst = 1'b0;
    #1 check_value("rst_release_ready", in_ready, 1);
    @(posedge clk); #1;

    clear_beats();
    xs[0] = 3;  ys[0] = 5;
    xs[1] = 2;  ys[1] = 7;
    xs[2] = 15; ys[2] = 15; lasts[2] = 1'b1;
    run_vector(0, 1'b0);

    clear_beats();
    for (int k = 0; k < N; k++) begin xs[k] = 15; ys[k] = 15; end
    run_vector(0, 1'b0);

    clear_beats();
    xs[0] = 1; ys[0] = 2;
    xs[1] = 3; ys[1] = 3; lasts[1] = 1'b1;
    run_vector(5, 1'b0);
    clear_beats();
    xs[0] = 1; ys[0] = 1; lasts[0] = 1'b1;
    run_vector(0, 1'b0);

    clear_beats();
    lasts[0] = 1'b1;
    run_vector(0, 1'b0);

    clear_beats();
    xs[0] = 5; ys[0] = 5;
    xs[1] = 9; ys[1] = 9; lasts[1] = 1'b1;
    out_ready = 1'b1;
    send_beats(2, 1'b0);
    check_value("drain_rst_pre_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check_value("drain_rst_valid", out_valid, 0);
    check_value("drain_rst_acc", out_acc, 0);
    check_value("drain_rst_count", out_count, 0);
    check_value("drain_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_value("drain_rst_release", in_ready, 1);
    @(posedge clk); #1;
    check_value("drain_rst_idle_valid", out_valid, 0);
    clear_beats();
    xs[0] = 4; ys[0] = 4; lasts[0] = 1'b1;
    run_vector(0, 1'b0);

    for (int v = 0; v < 25; v++) begin
      int terms;
      clear_beats();
      terms = $urandom_range(1, N);
      for (int k = 0; k < terms; k++) begin
        xs[k] = $urandom_range(0, 15);
        ys[k] = $urandom_range(0, 15);
      end
      if (terms < N || $urandom_range(0, 1) == 1) lasts[terms-1] = 1'b1;
      run_vector($urandom_range(0, 3), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
